uart_receiver: RTL and testbench

Serial 8N1 UART receiver that samples an asynchronous RX pin at 16× the baud rate, assembles bytes LSB-first, and pushes each valid byte into the write side of the UART byte FIFO. It is the ingress counterpart of the existing transmit path (UART_CTRL → FIFO → UARTSender) and runs entirely in the 50 MHz system domain. Framing errors and FIFO overruns are reported as single-cycle pulses.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 44 ++++
 rtl/uart_receiver.sv | 177 +++++++++++++++++
 tb/tb_uart_receiver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared states and framing constants for the UART receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int DATA_BITS  = 8;
   localparam int MID_SAMPLE = 7;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : 16x oversample tick generator, held at zero while disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
   parameter int CLK_DIV = 27
) (
   input  logic CLK,
   input  logic RST,
   input  logic EN,
   output logic TICK
);

   localparam logic [15:0] c_LAST = 16'(CLK_DIV - 1);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // Holding the count at zero while disabled phase-aligns ticks to enable.
   always_comb begin
      cnt_d = cnt_q;
      if (!EN) begin
         cnt_d = 16'd0;
      end else if (cnt_q == c_LAST) begin
         cnt_d = 16'd0;
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign TICK = EN && (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receiver, 16x oversampled, writes bytes into a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLK_DIV = 27
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       UART_RX,
   input  logic       FIFO_FULL,
   output logic       FIFO_WE,
   output logic [7:0] FIFO_Data,
   output logic       FRAME_ERR,
   output logic       OVERRUN,
   output logic       BUSY
);

   localparam logic [3:0] c_MID_SMP  = 4'(MID_SAMPLE);
   localparam logic [3:0] c_LAST_SMP = 4'(OVERSAMPLE - 1);
   localparam logic [2:0] c_LAST_BIT = 3'(DATA_BITS - 1);

   logic                 sync1_q;
   logic                 sync2_q;
   logic                 hist_q;
   logic                 w_rx;
   logic                 w_fall;
   logic                 w_tick;
   logic                 w_tick_en;

   rx_state_t            state_q, state_d;
   logic [3:0]           sample_q, sample_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [7:0]           data_q, data_d;
   logic                 we_q, we_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;

   // Idle-high line: reset the synchronizer to 1 so reset release is not an edge.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         hist_q  <= 1'b1;
      end else begin
         sync1_q <= UART_RX;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

   assign w_rx      = sync2_q;
   assign w_fall    = hist_q && !sync2_q;
   assign w_tick_en = (state_q != IDLE);

   uart_baud_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_baud_tick (
      .CLK  (CLK),
      .RST  (RST),
      .EN   (w_tick_en),
      .TICK (w_tick)
   );

   always_comb begin
      state_d  = state_q;
      sample_d = sample_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      data_d   = data_q;
      we_d     = 1'b0;
      ferr_d   = 1'b0;
      ovr_d    = 1'b0;

      case (state_q)
         IDLE: begin
            sample_d = 4'd0;
            bit_d    = 3'd0;
            if (w_fall) begin
               state_d = START;
            end
         end

         START: begin
            if (w_tick) begin
               if (sample_q == c_MID_SMP) begin
                  // Restart the count so data samples land a full bit later.
                  sample_d = 4'd0;
                  bit_d    = 3'd0;
                  state_d  = w_rx ? IDLE : DATA;
               end else begin
                  sample_d = sample_q + 4'd1;
               end
            end
         end

         DATA: begin
            if (w_tick) begin
               sample_d = sample_q + 4'd1;
               if (sample_q == c_LAST_SMP) begin
                  shift_d = {w_rx, shift_q[DATA_BITS-1:1]};
                  if (bit_q == c_LAST_BIT) begin
                     state_d = STOP;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end
            end
         end

         STOP: begin
            if (w_tick) begin
               sample_d = sample_q + 4'd1;
               if (sample_q == c_LAST_SMP) begin
                  if (w_rx) begin
                     if (FIFO_FULL) begin
                        ovr_d = 1'b1;
                     end else begin
                        we_d   = 1'b1;
                        data_d = shift_q;
                     end
                     state_d = IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = BREAK;
                  end
               end
            end
         end

         BREAK: begin
            if (w_rx) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         sample_q <= 4'd0;
         bit_q    <= 3'd0;
         shift_q  <= '0;
         data_q   <= 8'h00;
         we_q     <= 1'b0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sample_q <= sample_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         data_q   <= data_d;
         we_q     <= we_d;
         ferr_q   <= ferr_d;
         ovr_q    <= ovr_d;
      end
   end

   assign FIFO_WE   = we_q;
   assign FIFO_Data = data_q;
   assign FRAME_ERR = ferr_q;
   assign OVERRUN   = ovr_q;
   assign BUSY      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Scoreboard bench for uart_receiver with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

   localparam int BIT_CLKS = 64;
   localparam int K_WE = 0;
   localparam int K_FE = 1;
   localparam int K_OV = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       UART_RX = 1'b1;
   logic       FIFO_FULL = 1'b0;
   logic       FIFO_WE;
   logic [7:0] FIFO_Data;
   logic       FRAME_ERR;
   logic       OVERRUN;
   logic       BUSY;

   int         checks = 0;
   int         failures = 0;
   exp_t       exp_q[$];
   logic [7:0] last_written = 8'h00;

   uart_receiver #(.CLK_DIV(4)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .UART_RX   (UART_RX),
      .FIFO_FULL (FIFO_FULL),
      .FIFO_WE   (FIFO_WE),
      .FIFO_Data (FIFO_Data),
      .FRAME_ERR (FRAME_ERR),
      .OVERRUN   (OVERRUN),
      .BUSY      (BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Expected outcome of one frame, from the frame's content alone.
   task automatic expect_frame(input logic [7:0] d, input logic stop, input logic full);
      exp_t e;
      if (!stop) begin
         e.kind = K_FE;
         e.data = last_written;
      end else if (full) begin
         e.kind = K_OV;
         e.data = last_written;
      end else begin
         e.kind = K_WE;
         e.data = d;
         last_written = d;
      end
      exp_q.push_back(e);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic full,
                             input int low_hold);
      @(negedge CLK);
      FIFO_FULL = full;
      expect_frame(d, stop, full);
      UART_RX = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         UART_RX = d[i];
         wait_clks(BIT_CLKS);
      end
      UART_RX = stop;
      wait_clks(stop ? BIT_CLKS : low_hold);
      UART_RX = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_we"},   {31'd0, FIFO_WE},   32'd0);
      chk({tag, "_ferr"}, {31'd0, FRAME_ERR}, 32'd0);
      chk({tag, "_ovr"},  {31'd0, OVERRUN},   32'd0);
      chk({tag, "_busy"}, {31'd0, BUSY},      32'd0);
      chk({tag, "_data"}, {24'd0, FIFO_Data}, 32'd0);
   endtask

   // Monitor: every output pulse must match the oldest expected frame outcome.
   initial begin
      exp_t e;
      int   kind_act;
      forever begin
         @(posedge CLK);
         #1;
         if (!RST && (FIFO_WE || FRAME_ERR || OVERRUN)) begin
            chk("pulse_onehot", 32'($countones({FIFO_WE, FRAME_ERR, OVERRUN})), 32'd1);
            kind_act = FIFO_WE ? K_WE : (FRAME_ERR ? K_FE : K_OV);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pulse actual=kind%0d data=%0h required=no pulse",
                        kind_act, FIFO_Data);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_kind", 32'(kind_act), 32'(e.kind));
               chk("pulse_data", {24'd0, FIFO_Data}, {24'd0, e.data});
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic busy_seen;
      logic [7:0] d;
      logic       stop;
      logic       full;

      wait_clks(5);
      check_reset_outputs("reset");
      RST = 1'b0;
      wait_clks(20);

      // Normal byte.
      send_frame(8'h75, 1'b1, 1'b0, 0);
      chk("busy_after_75", {31'd0, BUSY}, 32'd0);
      wait_clks(20);

      // Short low glitch is a false start.
      busy_seen = 1'b0;
      @(negedge CLK);
      UART_RX = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (i == 20) UART_RX = 1'b1;
         @(negedge CLK);
         if (BUSY) busy_seen = 1'b1;
      end
      chk("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
      chk("glitch_idle", {31'd0, BUSY}, 32'd0);

      // Framing error followed by a held-low break.
      send_frame(8'hA5, 1'b0, 1'b0, 200);
      chk("break_busy", {31'd0, BUSY}, 32'd1);
      wait_clks(10);
      chk("break_released", {31'd0, BUSY}, 32'd0);
      wait_clks(20);

      // Overrun keeps previous data.
      send_frame(8'h3C, 1'b1, 1'b1, 0);
      wait_clks(20);

      // Back-to-back with no idle gap.
      send_frame(8'h00, 1'b1, 1'b0, 0);
      send_frame(8'hFF, 1'b1, 1'b0, 0);
      wait_clks(20);
      chk("b2b_drained", 32'(exp_q.size()), 32'd0);

      // Reset during bit 4 of 0x55 aborts the frame silently.
      @(negedge CLK);
      UART_RX = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         UART_RX = (i % 2 == 0);
         wait_clks(BIT_CLKS);
      end
      UART_RX = 1'b1;
      wait_clks(20);
      #2 RST = 1'b1;
      #1;
      check_reset_outputs("midframe_reset");
      last_written = 8'h00;
      wait_clks(5);
      RST = 1'b0;
      wait_clks(20);
      send_frame(8'hC3, 1'b1, 1'b0, 0);
      wait_clks(20);

      // Randomized frames: data, stop-bit errors, FIFO full and idle gaps.
      for (int n = 0; n < 25; n++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 5) != 0);
         full = ($urandom_range(0, 3) == 0);
         if (stop) begin
            send_frame(d, 1'b1, full, 0);
            wait_clks($urandom_range(0, 40));
         end else begin
            send_frame(d, 1'b0, full, $urandom_range(70, 200));
            wait_clks($urandom_range(10, 60));
         end
      end

      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
         @(negedge CLK);
      end
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      wait_clks(10);
      chk("final_idle", {31'd0, BUSY}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
